// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_pkg
// Brief   : Shared size codes, lane offsets and FSM encoding for the
//           load/store unit.
// Revision: 1.0 - initial release
// ============================================================================
package mem_access_pkg;

  // Access size codes as presented on i_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_INV  = 2'b11;

  // Big-endian byte offsets within a word (offset 0 is the MSB lane)
  localparam logic [1:0] OFS_B0 = 2'd0;  // [31:24]
  localparam logic [1:0] OFS_B1 = 2'd1;  // [23:16]
  localparam logic [1:0] OFS_B2 = 2'd2;  // [15:8]
  localparam logic [1:0] OFS_B3 = 2'd3;  // [7:0]
  localparam logic [1:0] OFS_H0 = 2'd0;  // [31:16]
  localparam logic [1:0] OFS_H1 = 2'd2;  // [15:0]

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  // True for an invalid size code or a half/word access off its natural alignment
  function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] ofs);
    req_is_bad = (size == SZ_INV) ||
                 ((size == SZ_HALF) && ofs[0]) ||
                 ((size == SZ_WORD) && (ofs != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_merge.sv
`default_nettype none
// ============================================================================
// Module  : lane_merge
// Brief   : Combinational byte-lane steering. Extracts and extends the
//           addressed lane of a RAM word for loads, and merges right-justified
//           store data into that lane for read-modify-write stores.
// Revision: 1.0 - initial release
// ============================================================================
module lane_merge
  import mem_access_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lane, extend it, and build the merged store word
  always_comb begin
    w_byte  = 8'h00;
    w_half  = 16'h0000;
    o_load  = i_word;
    o_store = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        case (i_offset)
          OFS_B0: begin
            w_byte  = i_word[31:24];
            o_store = {i_wdata[7:0], i_word[23:0]};
          end
          OFS_B1: begin
            w_byte  = i_word[23:16];
            o_store = {i_word[31:24], i_wdata[7:0], i_word[15:0]};
          end
          OFS_B2: begin
            w_byte  = i_word[15:8];
            o_store = {i_word[31:16], i_wdata[7:0], i_word[7:0]};
          end
          default: begin
            w_byte  = i_word[7:0];
            o_store = {i_word[31:8], i_wdata[7:0]};
          end
        endcase
        o_load = {{24{i_signed & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        if (i_offset == OFS_H1) begin
          w_half  = i_word[15:0];
          o_store = {i_word[31:16], i_wdata[15:0]};
        end else begin
          w_half  = i_word[31:16];
          o_store = {i_wdata[15:0], i_word[15:0]};
        end
        o_load = {{16{i_signed & w_half[15]}}, w_half};
      end
      default: begin
        o_load  = i_word;
        o_store = i_wdata;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_unit
// Brief   : Load/store unit between the datapath and a word-wide data RAM
//           with registered read data. Word stores write directly; sub-word
//           stores read, merge and write back. Misaligned or invalid
//           requests complete immediately with o_err.
// Revision: 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_signed,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_data
);

  state_t                r_state;
  state_t                w_next;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_ram_data;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_store;

  lane_merge u_lane_merge (
    .i_word   (i_ram_data),
    .i_offset (r_addr[1:0]),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_store  (w_store)
  );

  // State register; reset aborts any transaction at once
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state sequencing: word stores skip the read, sub-word stores read first
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          if (req_is_bad(i_size, i_addr[1:0]))   w_next = ST_ERR;
          else if (i_we && (i_size == SZ_WORD))  w_next = ST_WR;
          else                                   w_next = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: w_next = ST_RD_DATA;
      ST_RD_DATA: w_next = r_we ? ST_WR : ST_DONE;
      ST_WR:      w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      ST_ERR:     w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Request latch, read-data capture and store-word merge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_signed   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ram_data <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_we       <= i_we;
            r_size     <= i_size;
            r_signed   <= i_signed;
            r_addr     <= i_addr;
            r_wdata    <= i_wdata;
            // Word stores write this directly; sub-word stores overwrite it with the merge
            r_ram_data <= i_wdata;
          end
        end
        ST_RD_DATA: begin
          if (r_we) r_ram_data <= w_store;
          else      r_rdata    <= w_load;
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = (r_state == ST_DONE) || (r_state == ST_ERR);
  assign o_err      = (r_state == ST_ERR);
  assign o_ram_we   = (r_state == ST_WR);
  assign o_ram_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign o_ram_data = r_ram_data;
  assign o_rdata    = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_unit
// Brief   : Directed bench for mem_access_unit with a registered-read RAM model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tb_init = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sgn = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, err, ram_we;
  logic [31:0] rdata, ram_data;
  logic [31:0] ram_q = 32'h0;
  logic [7:0]  ram_addr;
  logic [31:0] mem [0:63];

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_size(size),
    .i_signed(sgn), .i_addr(addr), .i_wdata(wdata), .o_busy(busy),
    .o_done(done), .o_err(err), .o_rdata(rdata), .o_ram_addr(ram_addr),
    .o_ram_data(ram_data), .o_ram_we(ram_we), .i_ram_data(ram_q)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with registered read; preloaded while tb_init is high
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[8] <= 32'h11223344;
    end else if (ram_we) begin
      mem[ram_addr[7:2]] <= ram_data;
    end
    ram_q <= mem[ram_addr[7:2]];
  end

  task automatic do_req(input logic w, input logic [1:0] s, input logic sg,
                        input logic [7:0] a, input logic [31:0] d,
                        output int lat, output logic e, output logic sawwe);
    @(negedge clk);
    req = 1'b1; we = w; size = s; sgn = sg; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    lat = -1; e = 1'b0; sawwe = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ram_we) sawwe = 1'b1;
      if (done) begin
        lat = i;
        e = err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (err !== 1'b0)    begin errors++; $display("FAIL rst_err got %b want 0", err); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %b want 0", ram_we); end
    checks++; if (ram_addr !== 8'h00) begin errors++; $display("FAIL rst_ram_addr got %h want 00", ram_addr); end
    checks++; if (ram_data !== 32'h0) begin errors++; $display("FAIL rst_ram_data got %h want 0", ram_data); end
    checks++; if (rdata !== 32'h0)    begin errors++; $display("FAIL rst_rdata got %h want 0", rdata); end
    rst = 1'b0;
    tb_init = 1'b0;
  endtask

  task automatic test_load_word;
    int lat; logic e, sw;
    do_req(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, lat, e, sw);
    checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency got %0d want 3", lat); end
    checks++; if (rdata !== 32'h11223344) begin errors++; $display("FAIL lw_rdata got %h want 11223344", rdata); end
    checks++; if (e !== 1'b0)  begin errors++; $display("FAIL lw_err got %b want 0", e); end
    checks++; if (sw !== 1'b0) begin errors++; $display("FAIL lw_ram_we got %b want 0", sw); end
  endtask

  task automatic test_store_word_loads;
    int lat; logic e, sw;
    do_req(1'b1, 2'b10, 1'b0, 8'h24, 32'h80FF7F01, lat, e, sw);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency got %0d want 2", lat); end
    checks++; if (sw !== 1'b1) begin errors++; $display("FAIL sw_ram_we got %b want 1", sw); end
    do_req(1'b0, 2'b00, 1'b1, 8'h24, 32'h0, lat, e, sw);
    checks++; if (rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_s got %h want FFFFFF80", rdata); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL lb_latency got %0d want 3", lat); end
    do_req(1'b0, 2'b00, 1'b0, 8'h25, 32'h0, lat, e, sw);
    checks++; if (rdata !== 32'h000000FF) begin errors++; $display("FAIL lbu got %h want 000000FF", rdata); end
    do_req(1'b0, 2'b01, 1'b1, 8'h26, 32'h0, lat, e, sw);
    checks++; if (rdata !== 32'h00007F01) begin errors++; $display("FAIL lh_s got %h want 00007F01", rdata); end
    do_req(1'b0, 2'b01, 1'b1, 8'h24, 32'h0, lat, e, sw);
    checks++; if (rdata !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_s_hi got %h want FFFF80FF", rdata); end
  endtask

  task automatic test_subword_store;
    int lat; logic e, sw;
    do_req(1'b1, 2'b00, 1'b0, 8'h22, 32'h000000AA, lat, e, sw);
    checks++; if (lat !== 4) begin errors++; $display("FAIL sb_latency got %0d want 4", lat); end
    do_req(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, lat, e, sw);
    checks++; if (rdata !== 32'h1122AA44) begin errors++; $display("FAIL sb_readback got %h want 1122AA44", rdata); end
    do_req(1'b1, 2'b01, 1'b0, 8'h20, 32'h0000BEEF, lat, e, sw);
    checks++; if (lat !== 4) begin errors++; $display("FAIL sh_latency got %0d want 4", lat); end
    do_req(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, lat, e, sw);
    checks++; if (rdata !== 32'hBEEFAA44) begin errors++; $display("FAIL sh_readback got %h want BEEFAA44", rdata); end
  endtask

  task automatic test_errors;
    int lat; logic e, sw;
    do_req(1'b0, 2'b01, 1'b0, 8'h21, 32'h0, lat, e, sw);
    checks++; if (lat !== 1) begin errors++; $display("FAIL lh_mis_latency got %0d want 1", lat); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL lh_mis_err got %b want 1", e); end
    checks++; if (rdata !== 32'hBEEFAA44) begin errors++; $display("FAIL lh_mis_rdata got %h want BEEFAA44", rdata); end
    do_req(1'b1, 2'b10, 1'b0, 8'h22, 32'hDEADBEEF, lat, e, sw);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sw_mis_latency got %0d want 1", lat); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL sw_mis_err got %b want 1", e); end
    checks++; if (sw !== 1'b0) begin errors++; $display("FAIL sw_mis_ram_we got %b want 0", sw); end
    do_req(1'b0, 2'b11, 1'b0, 8'h20, 32'h0, lat, e, sw);
    checks++; if (lat !== 1) begin errors++; $display("FAIL size11_latency got %0d want 1", lat); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL size11_err got %b want 1", e); end
    checks++; if (rdata !== 32'hBEEFAA44) begin errors++; $display("FAIL size11_rdata got %h want BEEFAA44", rdata); end
    do_req(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, lat, e, sw);
    checks++; if (rdata !== 32'hBEEFAA44) begin errors++; $display("FAIL err_mem_intact got %h want BEEFAA44", rdata); end
  endtask

  task automatic test_reset_mid_rmw;
    int lat; logic e, sw;
    int ndone;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; sgn = 1'b0; addr = 8'h23; wdata = 32'h00000055;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);  // RD_WAIT
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", busy); end
    @(negedge clk);  // RD_DATA
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL mid_busy_after got %b want 0", busy); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL mid_ram_we got %b want 0", ram_we); end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", ndone); end
    do_req(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, lat, e, sw);
    checks++; if (rdata !== 32'hBEEFAA44) begin errors++; $display("FAIL mid_mem_intact got %h want BEEFAA44", rdata); end
  endtask

  task automatic test_busy_ignore;
    int lat, ndone; logic e, sw;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; sgn = 1'b0; addr = 8'h21; wdata = 32'h00000077;
    @(posedge clk);
    #1;
    // Second request held high while the first is in flight
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 8'h20; wdata = 32'hDEADBEEF;
    ndone = 0; lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (lat < 0) lat = i;
        req = 1'b0;
      end
    end
    req = 1'b0;
    checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_done_count got %0d want 1", ndone); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL busy_latency got %0d want 4", lat); end
    do_req(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, lat, e, sw);
    checks++; if (rdata !== 32'hBE77AA44) begin errors++; $display("FAIL busy_mem got %h want BE77AA44", rdata); end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store_word_loads();
    test_subword_store();
    test_errors();
    test_reset_mid_rmw();
    test_busy_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
